// File: rtl/gate_tester_if.sv
// ============================================================================
// Module      : gate_tester_if
// Description : Stimulus/response and status bundle between the gate tester
//               and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_tester_if;
    logic       start;
    logic [2:0] gate_sel;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_vec;
    logic       err_sel;

    // Environment side: requests sweeps and drives the gate-under-test output
    modport master (
        output start, gate_sel, c,
        input  a, b, busy, done, pass, fail_vec, err_sel
    );

    // Tester side
    modport slave (
        input  start, gate_sel, c,
        output a, b, busy, done, pass, fail_vec, err_sel
    );
endinterface

`default_nettype wire

// File: rtl/gate_tester.sv
// ============================================================================
// Module      : gate_tester
// Description : Sweeps a 2-input gate through all four {a,b} vectors and
//               checks its output against the selected boolean function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    gate_tester_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SWEEP  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

    logic [1:0] r_state, w_state;
    logic [2:0] r_sel,   w_sel;
    logic [1:0] r_idx,   w_idx;
    logic [3:0] r_cnt,   w_cnt;
    logic       r_a,     w_a;
    logic       r_b,     w_b;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic       r_pass,  w_pass;
    logic [3:0] r_fail,  w_fail;
    logic       r_err,   w_err;
    logic       w_expect;
    logic       w_sel_ok;

    assign w_sel_ok = (bus.gate_sel < 3'd6);

    // Reference response of the latched function for the vector now applied
    always_comb begin
        w_expect = 1'b0;
        case (r_sel)
            3'd0:    w_expect =   r_a & r_b;
            3'd1:    w_expect =   r_a | r_b;
            3'd2:    w_expect = ~(r_a & r_b);
            3'd3:    w_expect = ~(r_a | r_b);
            3'd4:    w_expect =   r_a ^ r_b;
            3'd5:    w_expect = ~(r_a ^ r_b);
            default: w_expect = 1'b0;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_fail  = r_fail;
        w_err   = r_err;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_sel_ok) begin
                        w_state = S_SWEEP;
                        w_sel   = bus.gate_sel;
                        w_idx   = 2'd0;
                        w_cnt   = 4'd0;
                        w_a     = 1'b0;
                        w_b     = 1'b0;
                        w_busy  = 1'b1;
                        w_pass  = 1'b0;
                        w_fail  = 4'b0000;
                        w_err   = 1'b0;
                    end else begin
                        // Invalid function: report a total failure without sweeping
                        w_state = S_REPORT;
                        w_done  = 1'b1;
                        w_a     = 1'b0;
                        w_b     = 1'b0;
                        w_busy  = 1'b0;
                        w_pass  = 1'b0;
                        w_fail  = 4'b1111;
                        w_err   = 1'b1;
                    end
                end
            end

            S_SWEEP: begin
                if (r_cnt == c_settle) begin
                    w_cnt = 4'd0;
                    if (bus.c != w_expect) begin
                        w_fail[r_idx] = 1'b1;
                    end
                    if (r_idx == 2'd3) begin
                        w_state = S_REPORT;
                        w_idx   = 2'd0;
                        w_a     = 1'b0;
                        w_b     = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_fail == 4'b0000);
                    end else begin
                        w_idx      = r_idx + 2'd1;
                        {w_a, w_b} = w_idx;
                    end
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end

            S_REPORT: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_fail  <= w_fail;
            r_err   <= w_err;
        end
    end

    assign bus.a        = r_a;
    assign bus.b        = r_b;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.fail_vec = r_fail;
    assign bus.err_sel  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gate_tester.sv
// ============================================================================
// Module      : tb_gate_tester
// Description : Directed self-checking bench for gate_tester (SETTLE_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_tester;

    logic clk;
    logic rst_n;
    int   c_mode;     // 0: NOR gate, 1: tied 0, 2: tied 1, 3: XOR gate
    int   n_tests;
    int   n_fail;

    gate_tester_if bus ();

    gate_tester #(.SETTLE_CYCLES(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test model
    always_comb begin
        case (c_mode)
            0:       bus.c = ~(bus.a | bus.b);
            1:       bus.c = 1'b0;
            2:       bus.c = 1'b1;
            default: bus.c = bus.a ^ bus.b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".a"},    32'(bus.a),        32'd0);
        chk({tag, ".b"},    32'(bus.b),        32'd0);
        chk({tag, ".busy"}, 32'(bus.busy),     32'd0);
        chk({tag, ".done"}, 32'(bus.done),     32'd0);
        chk({tag, ".pass"}, 32'(bus.pass),     32'd0);
        chk({tag, ".fail"}, 32'(bus.fail_vec), 32'd0);
        chk({tag, ".err"},  32'(bus.err_sel),  32'd0);
    endtask

    // Full sweep: start sampled at edge 0, vectors change at edges 3/6/9,
    // done visible in the cycle after edge 12.
    task automatic run_sweep(input logic [2:0] sel, input int mode, input bit disturb,
                             input logic exp_pass, input logic [3:0] exp_fail,
                             input string tag);
        @(negedge clk);
        c_mode       = mode;
        bus.gate_sel = sel;
        bus.start    = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            if (k < 12) begin
                chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
                chk({tag, ".done"}, 32'(bus.done), 32'd0);
                if (k % 3 == 0)
                    chk({tag, ".ab"}, 32'({bus.a, bus.b}), 32'(k / 3));
                if (k == 0) begin
                    chk({tag, ".clr_fail"}, 32'(bus.fail_vec), 32'd0);
                    chk({tag, ".clr_err"},  32'(bus.err_sel),  32'd0);
                end
            end else if (k == 12) begin
                chk({tag, ".done12"}, 32'(bus.done),        32'd1);
                chk({tag, ".busy12"}, 32'(bus.busy),        32'd0);
                chk({tag, ".ab12"},   32'({bus.a, bus.b}),  32'd0);
                chk({tag, ".pass"},   32'(bus.pass),        32'(exp_pass));
                chk({tag, ".fail"},   32'(bus.fail_vec),    32'(exp_fail));
                chk({tag, ".err"},    32'(bus.err_sel),     32'd0);
            end else begin
                chk({tag, ".done13"}, 32'(bus.done), 32'd0);
                chk({tag, ".busy13"}, 32'(bus.busy), 32'd0);
                chk({tag, ".pass13"}, 32'(bus.pass), 32'(exp_pass));
            end
            if (disturb && k == 4) begin
                bus.start    = 1'b1;
                bus.gate_sel = 3'b000;
            end
            if (disturb && k == 5) begin
                bus.start    = 1'b0;
                bus.gate_sel = 3'b101;
            end
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        c_mode       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.gate_sel = 3'b000;

        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(3'b011, 0, 1'b0, 1'b1, 4'b0000, "nor_pass");
        run_sweep(3'b000, 0, 1'b0, 1'b0, 4'b1001, "nor_as_and");
        run_sweep(3'b011, 1, 1'b0, 1'b0, 4'b0001, "tied0");
        run_sweep(3'b011, 2, 1'b0, 1'b0, 4'b1110, "tied1");
        run_sweep(3'b100, 3, 1'b0, 1'b1, 4'b0000, "xor_pass");

        // Invalid function select
        @(negedge clk);
        bus.gate_sel = 3'b111;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        chk("inv.done", 32'(bus.done),       32'd1);
        chk("inv.pass", 32'(bus.pass),       32'd0);
        chk("inv.fail", 32'(bus.fail_vec),   32'hF);
        chk("inv.err",  32'(bus.err_sel),    32'd1);
        chk("inv.busy", 32'(bus.busy),       32'd0);
        chk("inv.ab",   32'({bus.a, bus.b}), 32'd0);
        @(negedge clk);
        chk("inv.done2", 32'(bus.done), 32'd0);
        chk("inv.busy2", 32'(bus.busy), 32'd0);

        // Mid-sweep start and gate_sel changes are ignored
        run_sweep(3'b011, 0, 1'b1, 1'b1, 4'b0000, "disturb");
        bus.gate_sel = 3'b011;
        repeat (3) @(negedge clk);
        chk("disturb.nodone", 32'(bus.done), 32'd0);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        c_mode       = 0;
        bus.gate_sel = 3'b011;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst.pre_a", 32'(bus.a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("rst_async");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst.nodone", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst.idle_busy", 32'(bus.busy), 32'd0);
        end
        run_sweep(3'b011, 0, 1'b0, 1'b1, 4'b0000, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
